// File: rtl/motor_duty_ramp.sv
// Slews duty_cycle toward a commanded target at a fixed rate and zeroes it on a stall.
// Optional hall-code fault detection is compiled in with `define HALL_FAULT_EN.
module motor_duty_ramp #(
  parameter int DUTY_WIDTH    = 8,
  parameter int RAMP_DIV      = 1024,
  parameter int STEP          = 1,
  parameter int STALL_TIMEOUT = 1048576
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [DUTY_WIDTH-1:0] cmd_duty,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            hall,
  output logic [DUTY_WIDTH-1:0] duty_cycle,
  output logic                  at_target,
  output logic                  stalled,
  output logic                  hall_fault
);

  localparam int PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int SW = (STALL_TIMEOUT > 1) ? $clog2(STALL_TIMEOUT) : 1;
  localparam logic [PW-1:0]         PRESC_MAX = PW'(RAMP_DIV - 1);
  localparam logic [SW-1:0]         STALL_MAX = SW'(STALL_TIMEOUT - 1);
  localparam logic [DUTY_WIDTH:0]   STEP_W    = (DUTY_WIDTH + 1)'(STEP);

  typedef enum logic [1:0] {S_DISABLED, S_RAMP, S_HOLD, S_STALL} state_t;

  state_t                state_q, state_d;
  logic [DUTY_WIDTH-1:0] duty_q, duty_d;
  logic [DUTY_WIDTH-1:0] target_q, target_d;
  logic [PW-1:0]         presc_q, presc_d;
  logic [SW-1:0]         stall_cnt_q, stall_cnt_d;
  logic [2:0]            hall_s1_q, hall_s2_q, hall_prev_q;
  logic                  at_target_q, stalled_q, hall_fault_q, hall_fault_d;

  logic                  tick, hall_edge, stall_hit, fault_hit;
  logic [DUTY_WIDTH:0]   up_sum, dn_diff;
  logic [DUTY_WIDTH-1:0] ramp_val;

`ifdef HALL_FAULT_EN
  // Hall codes are only judged once the synchronizer holds real samples,
  // so the all-zero reset contents never read as a fault.
  logic [1:0] primed_q;
  logic       hall_bad;
  always_ff @(posedge clock) begin
    if (reset) primed_q <= 2'b00;
    else       primed_q <= {primed_q[0], 1'b1};
  end
  assign hall_bad     = primed_q[1] && (hall_s2_q == 3'b000 || hall_s2_q == 3'b111);
  assign hall_fault_d = hall_fault_q | hall_bad;
  assign fault_hit    = hall_fault_q | hall_bad;
`else
  assign hall_fault_d = 1'b0;
  assign fault_hit    = 1'b0;
`endif

  assign cmd_ready = !reset && (state_q != S_STALL);

  always_comb begin
    tick      = (presc_q == PRESC_MAX);
    presc_d   = tick ? '0 : presc_q + 1'b1;
    hall_edge = (hall_s2_q != hall_prev_q);

    // Extra MSB catches overflow on the way up and borrow on the way down.
    up_sum  = {1'b0, duty_q} + STEP_W;
    dn_diff = {1'b0, duty_q} - STEP_W;
    if (duty_q < target_q)
      ramp_val = (up_sum > {1'b0, target_q}) ? target_q : up_sum[DUTY_WIDTH-1:0];
    else
      ramp_val = (dn_diff[DUTY_WIDTH] || dn_diff < {1'b0, target_q}) ? target_q
                                                                      : dn_diff[DUTY_WIDTH-1:0];

    stall_hit = (state_q == S_RAMP || state_q == S_HOLD) && (duty_q != '0) &&
                (stall_cnt_q == STALL_MAX) && !hall_edge;

    if (hall_edge || duty_q == '0 || state_q == S_DISABLED || state_q == S_STALL)
      stall_cnt_d = '0;
    else if (stall_cnt_q != STALL_MAX)
      stall_cnt_d = stall_cnt_q + 1'b1;
    else
      stall_cnt_d = stall_cnt_q;

    target_d = (cmd_valid && cmd_ready) ? cmd_duty : target_q;
    state_d  = state_q;
    duty_d   = duty_q;

    if (!enable) begin
      state_d = S_DISABLED;
      duty_d  = '0;
    end else begin
      case (state_q)
        S_DISABLED: begin
          duty_d = '0;
          if (!hall_fault_q) state_d = (target_q != '0) ? S_RAMP : S_HOLD;
        end
        S_RAMP: begin
          if (stall_hit || fault_hit) begin
            state_d = S_STALL;
            duty_d  = '0;
          end else if (duty_q == target_q) begin
            state_d = S_HOLD;
          end else if (tick) begin
            duty_d = ramp_val;
          end
        end
        S_HOLD: begin
          if (stall_hit || fault_hit) begin
            state_d = S_STALL;
            duty_d  = '0;
          end else if (target_q != duty_q) begin
            state_d = S_RAMP;
          end
        end
        default: begin
          state_d = S_STALL;
          duty_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_DISABLED;
      duty_q       <= '0;
      target_q     <= '0;
      presc_q      <= '0;
      stall_cnt_q  <= '0;
      hall_s1_q    <= 3'b000;
      hall_s2_q    <= 3'b000;
      hall_prev_q  <= 3'b000;
      at_target_q  <= 1'b0;
      stalled_q    <= 1'b0;
      hall_fault_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      duty_q       <= duty_d;
      target_q     <= target_d;
      presc_q      <= presc_d;
      stall_cnt_q  <= stall_cnt_d;
      hall_s1_q    <= hall;
      hall_s2_q    <= hall_s1_q;
      hall_prev_q  <= hall_s2_q;
      at_target_q  <= (state_d == S_HOLD) && (duty_d == target_d);
      stalled_q    <= (state_d == S_STALL);
      hall_fault_q <= hall_fault_d;
    end
  end

  assign duty_cycle = duty_q;
  assign at_target  = at_target_q;
  assign stalled    = stalled_q;
  assign hall_fault = hall_fault_q;

endmodule
